// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, state encoding and select decode for demux_1_4_stream.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
    function automatic logic [NUM_CH-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction
endpackage

// File: rtl/demux_chan_cnt.sv
// demux_chan_cnt: CNT_W-bit wrapping transfer counter with enable.
// Ports: clk, rst_n (sync, active-low), en (count this cycle), cnt (current count).
module demux_chan_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1-to-4 valid/ready stream demux with one output register stage.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_sel from the producer;
// out_valid/out_ready per channel (bit i = channel i), out_data shared by all channels;
// cnt_flat per-channel transfer counts, present only when DEMUX_CNT_EN is defined.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat
`endif
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              drain, load;

    always_comb begin
        drain     = (state_q == ST_FULL) && out_ready[sel_q];
        // Combinational out_ready -> in_ready path allows a drain and a fill in the same cycle.
        in_ready  = (state_q == ST_EMPTY) || out_ready[sel_q];
        load      = in_valid && in_ready;
        state_d   = load ? ST_FULL : (drain ? ST_EMPTY : state_q);
        out_valid = (state_q == ST_FULL) ? sel2onehot(sel_q) : '0;
        out_data  = data_q;
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
        end

`ifdef DEMUX_CNT_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        demux_chan_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (out_valid[i] && out_ready[i]),
            .cnt  (cnt_flat[i*CNT_W +: CNT_W])
        );
    end
`endif
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: table-driven per-cycle checks plus a handshake scoreboard.
module tb_demux_1_4_stream;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        in_sel = '0;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = '0;
    logic [DATA_W-1:0] out_data;
`ifdef DEMUX_CNT_EN
    logic [4*CNT_W-1:0] cnt_flat;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r, iv;
        logic [7:0] d;
        logic [1:0] s;
        logic [3:0] ordy, ev;
        logic [7:0] ed;
        logic       cd, eir;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
    } item_t;

    vec_t  vecs[$];
    item_t sb[$];

    always #5 clk = ~clk;

    demux_1_4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_flat (cnt_flat)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic r, iv, input logic [7:0] d, input logic [1:0] s,
                               input logic [3:0] ordy, ev, input logic [7:0] ed,
                               input logic cd, eir);
        vec_t x;
        x.r = r; x.iv = iv; x.d = d; x.s = s; x.ordy = ordy;
        x.ev = ev; x.ed = ed; x.cd = cd; x.eir = eir;
        return x;
    endfunction

    // Drive one cycle of inputs, check outputs before the edge, then track handshakes.
    task automatic cycle(input vec_t x, input string tag);
        item_t it;
        rst_n = x.r; in_valid = x.iv; in_data = x.d; in_sel = x.s; out_ready = x.ordy;
        @(negedge clk);
        chk({tag, " out_valid"}, out_valid, x.ev);
        chk({tag, " in_ready"}, in_ready, x.eir);
        chk({tag, " onehot"}, $countones(out_valid) <= 1, 1);
        if (x.cd) chk({tag, " out_data"}, out_data, x.ed);
        if (!rst_n) sb.delete();
        else begin
            if (|(out_valid & out_ready)) begin
                chk({tag, " sb_nonempty"}, sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    it = sb.pop_front();
                    chk({tag, " sb_data"}, out_data, it.d);
                    chk({tag, " sb_chan"}, out_valid, 4'b0001 << it.s);
                end
            end
            if (in_valid && in_ready) begin
                it.d = in_data; it.s = in_sel;
                sb.push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        vecs.push_back(v(1, 1, 8'hA5, 2, 4'hF, 4'b0000, 8'h00, 1, 1));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'hF, 4'b0100, 8'hA5, 1, 1));
        vecs.push_back(v(1, 1, 8'h3C, 1, 4'hD, 4'b0000, 8'h00, 0, 1));
        vecs.push_back(v(1, 1, 8'h77, 3, 4'hD, 4'b0010, 8'h3C, 1, 0));
        vecs.push_back(v(1, 1, 8'h77, 3, 4'hD, 4'b0010, 8'h3C, 1, 0));
        vecs.push_back(v(1, 1, 8'h77, 3, 4'hD, 4'b0010, 8'h3C, 1, 0));
        vecs.push_back(v(1, 1, 8'h77, 3, 4'hF, 4'b0010, 8'h3C, 1, 1));
        vecs.push_back(v(1, 0, 8'h00, 3, 4'h7, 4'b1000, 8'h77, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h7, 4'b1000, 8'h77, 1, 0));
        vecs.push_back(v(1, 1, 8'h55, 0, 4'h7, 4'b1000, 8'h77, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h8, 4'b1000, 8'h77, 1, 1));
        vecs.push_back(v(1, 1, 8'h01, 0, 4'hF, 4'b0000, 8'h00, 0, 1));
        vecs.push_back(v(1, 1, 8'h02, 1, 4'hF, 4'b0001, 8'h01, 1, 1));
        vecs.push_back(v(1, 1, 8'h03, 2, 4'hF, 4'b0010, 8'h02, 1, 1));
        vecs.push_back(v(1, 1, 8'h04, 3, 4'hF, 4'b0100, 8'h03, 1, 1));
        vecs.push_back(v(1, 1, 8'hAA, 1, 4'h0, 4'b1000, 8'h04, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h0, 4'b1000, 8'h04, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 0, 4'h0, 4'b1000, 8'h04, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h0, 4'b0000, 8'h00, 1, 1));
        vecs.push_back(v(1, 1, 8'hC3, 0, 4'h1, 4'b0000, 8'h00, 1, 1));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h1, 4'b0001, 8'hC3, 1, 1));
        vecs.push_back(v(1, 0, 8'h00, 0, 4'h1, 4'b0000, 8'h00, 0, 1));
        foreach (vecs[k]) cycle(vecs[k], $sformatf("vec%0d", k));
        chk("sb_drained", sb.size(), 0);

`ifdef DEMUX_CNT_EN
        cycle(v(0, 0, 8'h00, 0, 4'hF, 4'b0000, 8'h00, 0, 1), "cnt_rst");
        chk("cnt_cleared", cnt_flat, 16'h0000);
        for (int k = 0; k <= 17; k++)
            cycle(v(1, k < 17, 8'(k + 8'h10), 2, 4'hF, (k == 0) ? 4'b0000 : 4'b0100,
                    8'(k + 8'h0F), k != 0, 1), $sformatf("cnt_ch2_%0d", k));
        cycle(v(1, 1, 8'hE0, 0, 4'hF, 4'b0000, 8'h00, 0, 1), "cnt_ch0_a");
        cycle(v(1, 0, 8'h00, 0, 4'hF, 4'b0001, 8'hE0, 1, 1), "cnt_ch0_b");
        cycle(v(1, 0, 8'h00, 0, 4'hF, 4'b0000, 8'h00, 0, 1), "cnt_ch0_c");
        chk("cnt_flat", cnt_flat, 16'h0101);
        chk("sb_drained_cnt", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
